// File: rtl/wormhole_out_arbiter.sv
// Per-output-port wormhole arbiter: round-robin among five input gates, with the winner held from head to tail.
// Optional feature macro WH_ARB_TIMEOUT_EN adds a stall timeout that force-releases a stuck lock.
module wormhole_out_arbiter #(
    parameter logic [2:0] PORT           = 3'd0,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       out_ready,
    input  logic [2:0] pe_gate,
    input  logic [2:0] north_gate,
    input  logic [2:0] east_gate,
    input  logic [2:0] south_gate,
    input  logic [2:0] west_gate,
    input  logic [9:0] flit_type,
    output logic [2:0] grant,
    output logic       grant_vld,
    output logic [4:0] ack,
    output logic       drop
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [2:0] NO_GRANT = 3'd7;

    if (PORT > 3'd4 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("wormhole_out_arbiter: PORT must be 0..4 and TIMEOUT_CYCLES >= 1");
    end

    function automatic logic [2:0] wrap5(input logic [3:0] v);
        logic [2:0] r;
        if (v >= 4'd5) begin
            r = 3'(v - 4'd5);
        end else begin
            r = v[2:0];
        end
        return r;
    endfunction

    state_t     state_r, state_n;
    logic [2:0] owner_r, owner_n;
    logic [2:0] rr_ptr_r, rr_ptr_n;
    logic [2:0] grant_r, grant_n;
    logic       grant_vld_r, grant_vld_n;
    logic [4:0] ack_r, ack_n;
    logic       drop_r, drop_n;
    logic       gap_r, gap_n;

    logic [2:0] gate_s [5];
    logic [1:0] type_s [5];
    logic [4:0] req_s;
    logic [4:0] head_s;
    logic       found_s;
    logic [2:0] winner_s;
    logic [2:0] idx_s;
    logic       consume_s;

`ifdef WH_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] cnt_r, cnt_n;
`endif

    // Decode requests and pick the first head-eligible input at or after rr_ptr.
    always_comb begin
        gate_s[0] = north_gate;
        gate_s[1] = east_gate;
        gate_s[2] = south_gate;
        gate_s[3] = west_gate;
        gate_s[4] = pe_gate;
        found_s   = 1'b0;
        winner_s  = 3'd0;
        idx_s     = 3'd0;
        for (int i = 0; i < 5; i++) begin
            type_s[i] = flit_type[2*i +: 2];
            req_s[i]  = (gate_s[i] == PORT);
            head_s[i] = req_s[i] && type_s[i][1];
        end
        for (int k = 0; k < 5; k++) begin
            idx_s = wrap5({1'b0, rr_ptr_r} + 4'(k));
            if (!found_s && head_s[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
        consume_s = req_s[owner_r] && out_ready;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_n     = state_r;
        owner_n     = owner_r;
        rr_ptr_n    = rr_ptr_r;
        grant_n     = grant_r;
        grant_vld_n = grant_vld_r;
        ack_n       = 5'b00000;
        drop_n      = 1'b0;
        gap_n       = gap_r;
`ifdef WH_ARB_TIMEOUT_EN
        cnt_n       = cnt_r;
`endif
        if (!enable) begin
            ack_n  = 5'b00000;
            drop_n = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gap_r) begin
                        // Guaranteed idle cycle after a tail before re-arbitrating.
                        gap_n       = 1'b0;
                        grant_n     = NO_GRANT;
                        grant_vld_n = 1'b0;
                    end else if (out_ready && found_s) begin
                        grant_n     = winner_s;
                        grant_vld_n = 1'b1;
                        ack_n       = 5'b00001 << winner_s;
                        rr_ptr_n    = wrap5({1'b0, winner_s} + 4'd1);
                        owner_n     = winner_s;
`ifdef WH_ARB_TIMEOUT_EN
                        cnt_n       = '0;
`endif
                        if (type_s[winner_s] == 2'b10) begin
                            state_n = ST_LOCKED;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        grant_n     = NO_GRANT;
                        grant_vld_n = 1'b0;
                    end
                end
                ST_LOCKED: begin
                    grant_n     = owner_r;
                    grant_vld_n = 1'b1;
                    if (consume_s) begin
                        ack_n = 5'b00001 << owner_r;
`ifdef WH_ARB_TIMEOUT_EN
                        cnt_n = '0;
`endif
                        if (type_s[owner_r] == 2'b01) begin
                            state_n = ST_IDLE;
                            gap_n   = 1'b1;
                        end else begin
                            state_n = ST_LOCKED;
                        end
                    end else begin
`ifdef WH_ARB_TIMEOUT_EN
                        if (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_n     = ST_IDLE;
                            grant_n     = NO_GRANT;
                            grant_vld_n = 1'b0;
                            drop_n      = 1'b1;
                            cnt_n       = '0;
                        end else begin
                            cnt_n = cnt_r + CNT_W'(1);
                        end
`else
                        state_n = ST_LOCKED;
`endif
                    end
                end
                default: begin
                    state_n     = ST_IDLE;
                    grant_n     = NO_GRANT;
                    grant_vld_n = 1'b0;
                    gap_n       = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            owner_r     <= 3'd0;
            rr_ptr_r    <= 3'd0;
            grant_r     <= NO_GRANT;
            grant_vld_r <= 1'b0;
            ack_r       <= 5'b00000;
            drop_r      <= 1'b0;
            gap_r       <= 1'b0;
`ifdef WH_ARB_TIMEOUT_EN
            cnt_r       <= '0;
`endif
        end else begin
            state_r     <= state_n;
            owner_r     <= owner_n;
            rr_ptr_r    <= rr_ptr_n;
            grant_r     <= grant_n;
            grant_vld_r <= grant_vld_n;
            ack_r       <= ack_n;
            drop_r      <= drop_n;
            gap_r       <= gap_n;
`ifdef WH_ARB_TIMEOUT_EN
            cnt_r       <= cnt_n;
`endif
        end
    end

    assign grant     = grant_r;
    assign grant_vld = grant_vld_r;
    assign ack       = ack_r;
    assign drop      = drop_r;

endmodule

// File: tb/tb_wormhole_out_arbiter.sv
// Scoreboard bench for wormhole_out_arbiter: one instance per output port, shared input stimulus.
module tb_wormhole_out_arbiter;

    typedef struct {
        int         port;
        logic [2:0] g;
        logic       v;
        logic [4:0] a;
        logic       d;
        string      nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       out_ready;
    logic [2:0] pe_gate, north_gate, east_gate, south_gate, west_gate;
    logic [9:0] flit_type;
    logic [2:0] grant_w [5];
    logic       vld_w   [5];
    logic [4:0] ack_w   [5];
    logic       drop_w  [5];

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        wormhole_out_arbiter #(.PORT(3'(g)), .TIMEOUT_CYCLES(4)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .out_ready  (out_ready),
            .pe_gate    (pe_gate),
            .north_gate (north_gate),
            .east_gate  (east_gate),
            .south_gate (south_gate),
            .west_gate  (west_gate),
            .flit_type  (flit_type),
            .grant      (grant_w[g]),
            .grant_vld  (vld_w[g]),
            .ack        (ack_w[g]),
            .drop       (drop_w[g])
        );
    end

    task automatic set_type(input int idx, input logic [1:0] t);
        flit_type[2*idx +: 2] = t;
    endtask

    task automatic idle_inputs();
        enable     = 1'b1;
        out_ready  = 1'b1;
        pe_gate    = 3'd7;
        north_gate = 3'd7;
        east_gate  = 3'd7;
        south_gate = 3'd7;
        west_gate  = 3'd7;
        flit_type  = 10'b0;
    endtask

    // Push the expectation for the current stimulus, clock once, pop and compare.
    task automatic cyc(input int p, input logic [2:0] g, input logic v,
                       input logic [4:0] a, input logic d, input string nm);
        exp_t e;
        sb_q.push_back('{p, g, v, a, d, nm});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_cmp++;
        if (grant_w[e.port] !== e.g) begin
            n_err++;
            $display("FAIL %s grant: got %0d want %0d", e.nm, grant_w[e.port], e.g);
        end
        n_cmp++;
        if (vld_w[e.port] !== e.v) begin
            n_err++;
            $display("FAIL %s grant_vld: got %b want %b", e.nm, vld_w[e.port], e.v);
        end
        n_cmp++;
        if (ack_w[e.port] !== e.a) begin
            n_err++;
            $display("FAIL %s ack: got %b want %b", e.nm, ack_w[e.port], e.a);
        end
        n_cmp++;
        if (drop_w[e.port] !== e.d) begin
            n_err++;
            $display("FAIL %s drop: got %b want %b", e.nm, drop_w[e.port], e.d);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            n_cmp++;
            if (grant_w[p] !== 3'd7 || vld_w[p] !== 1'b0 || ack_w[p] !== 5'b0 || drop_w[p] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_port%0d: got g=%0d v=%b a=%b d=%b want g=7 v=0 a=0 d=0",
                         p, grant_w[p], vld_w[p], ack_w[p], drop_w[p]);
            end
        end
        cyc(0, 3'd7, 1'b0, 5'b00000, 1'b0, "reset_idle");
    endtask

    task automatic test_single();
        do_reset();
        north_gate = 3'd1;
        set_type(0, 2'b11);
        cyc(1, 3'd0, 1'b1, 5'b00001, 1'b0, "single_grant");
        north_gate = 3'd7;
        cyc(1, 3'd7, 1'b0, 5'b00000, 1'b0, "single_release");
    endtask

    task automatic test_enable();
        do_reset();
        enable     = 1'b0;
        north_gate = 3'd1;
        set_type(0, 2'b10);
        cyc(1, 3'd7, 1'b0, 5'b00000, 1'b0, "en_frozen_idle");
        enable = 1'b1;
        cyc(1, 3'd0, 1'b1, 5'b00001, 1'b0, "en_head");
        enable = 1'b0;
        set_type(0, 2'b00);
        cyc(1, 3'd0, 1'b1, 5'b00000, 1'b0, "en_frozen_lock");
        enable = 1'b1;
        cyc(1, 3'd0, 1'b1, 5'b00001, 1'b0, "en_resume");
    endtask

    task automatic test_wormhole();
        do_reset();
        east_gate = 3'd2;
        west_gate = 3'd2;
        set_type(3, 2'b10);
        set_type(1, 2'b10);
        cyc(2, 3'd1, 1'b1, 5'b00010, 1'b0, "wh_head");
        set_type(1, 2'b00);
        cyc(2, 3'd1, 1'b1, 5'b00010, 1'b0, "wh_body1");
        cyc(2, 3'd1, 1'b1, 5'b00010, 1'b0, "wh_body2");
        set_type(1, 2'b01);
        cyc(2, 3'd1, 1'b1, 5'b00010, 1'b0, "wh_tail");
        east_gate = 3'd7;
        cyc(2, 3'd7, 1'b0, 5'b00000, 1'b0, "wh_gap");
        cyc(2, 3'd3, 1'b1, 5'b01000, 1'b0, "wh_next_west");
    endtask

    task automatic test_back_to_back();
        logic [4:0] oh;
        do_reset();
        pe_gate    = 3'd4;
        north_gate = 3'd4;
        east_gate  = 3'd4;
        south_gate = 3'd4;
        west_gate  = 3'd4;
        flit_type  = 10'b11_11_11_11_11;
        for (int k = 0; k < 6; k++) begin
            oh = 5'b00001 << (k % 5);
            cyc(4, 3'(k % 5), 1'b1, oh, 1'b0, $sformatf("rr_%0d", k));
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        pe_gate = 3'd0;
        set_type(4, 2'b10);
        cyc(0, 3'd4, 1'b1, 5'b10000, 1'b0, "bp_head");
        set_type(4, 2'b00);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 3'd4, 1'b1, 5'b00000, 1'b0, $sformatf("bp_stall%0d", k));
        end
        out_ready = 1'b1;
        cyc(0, 3'd4, 1'b1, 5'b10000, 1'b0, "bp_resume");
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        south_gate = 3'd3;
        set_type(2, 2'b10);
        cyc(3, 3'd2, 1'b1, 5'b00100, 1'b0, "mid_head");
        set_type(2, 2'b00);
        cyc(3, 3'd2, 1'b1, 5'b00100, 1'b0, "mid_body");
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (grant_w[3] !== 3'd7 || vld_w[3] !== 1'b0) begin
            n_err++;
            $display("FAIL mid_async_reset: got g=%0d v=%b want g=7 v=0", grant_w[3], vld_w[3]);
        end
        rst        = 1'b1;
        south_gate = 3'd7;
        north_gate = 3'd3;
        west_gate  = 3'd3;
        set_type(0, 2'b11);
        set_type(3, 2'b11);
        cyc(3, 3'd0, 1'b1, 5'b00001, 1'b0, "mid_rr_zero");
    endtask

    task automatic test_timeout();
        do_reset();
        pe_gate = 3'd0;
        set_type(4, 2'b10);
        cyc(0, 3'd4, 1'b1, 5'b10000, 1'b0, "to_head");
        pe_gate = 3'd7;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 3'd4, 1'b1, 5'b00000, 1'b0, $sformatf("to_stall%0d", k));
        end
`ifdef WH_ARB_TIMEOUT_EN
        cyc(0, 3'd7, 1'b0, 5'b00000, 1'b1, "to_drop");
        cyc(0, 3'd7, 1'b0, 5'b00000, 1'b0, "to_after");
`else
        cyc(0, 3'd4, 1'b1, 5'b00000, 1'b0, "to_held");
        cyc(0, 3'd4, 1'b1, 5'b00000, 1'b0, "to_held2");
`endif
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_enable();
        test_wormhole();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
